// File: rtl/whack_a_mole_core.sv
// Four-hole whack-a-mole game core: LFSR-driven mole selection, synchronised
// edge-detected buttons, and a saturating 4-bit hit counter.
module whack_a_mole_core #(
  parameter int unsigned MOLE_TIME = 16,
  parameter int unsigned GAP_TIME  = 4,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in1,
  input  logic       in2,
  input  logic       in3,
  input  logic       in4,
  output logic [3:0] count,
  output logic       mo1,
  output logic       mo2,
  output logic       mo3,
  output logic       mo4
);

  typedef enum logic {GAP, UP} state_e;

  localparam logic [7:0] GAP_LAST  = 8'(GAP_TIME - 1);
  localparam logic [7:0] MOLE_LAST = 8'(MOLE_TIME - 1);

  state_e     state_q;
  logic [7:0] timer_q;
  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic [3:0] mo_q;
  logic [3:0] count_q;
  logic [3:0] count_d;
  logic [3:0] s1_q;
  logic [3:0] s2_q;
  logic [3:0] s2d_q;
  logic [3:0] press;
  logic       hit;

  // mo_q is one-hot while UP, so masking presses with it selects the matching button.
  always_comb begin
    press   = s2_q & ~s2d_q;
    hit     = |(press & mo_q);
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    count_d = (count_q == 4'hF) ? count_q : count_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GAP;
      timer_q <= '0;
      lfsr_q  <= LFSR_SEED;
      mo_q    <= '0;
      count_q <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      s2d_q   <= '0;
    end else begin
      s1_q   <= {in4, in3, in2, in1};
      s2_q   <= s1_q;
      s2d_q  <= s2_q;
      lfsr_q <= lfsr_d;
      case (state_q)
        GAP: begin
          if (timer_q == GAP_LAST) begin
            state_q <= UP;
            timer_q <= '0;
            mo_q    <= 4'(4'b0001 << lfsr_q[1:0]);
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        UP: begin
          if (hit) begin
            count_q <= count_d;
            mo_q    <= '0;
            state_q <= GAP;
            timer_q <= '0;
          end else if (timer_q == MOLE_LAST) begin
            mo_q    <= '0;
            state_q <= GAP;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        default: begin
          state_q <= GAP;
          timer_q <= '0;
          mo_q    <= '0;
        end
      endcase
    end
  end

  assign count = count_q;
  assign {mo4, mo3, mo2, mo1} = mo_q;

endmodule

// File: tb/tb_whack_a_mole_core.sv
// Scoreboard bench for whack_a_mole_core: a countdown-based game model predicts
// count/mole outputs every cycle; a negedge monitor pops and compares.
module tb_whack_a_mole_core;

  localparam int unsigned MT   = 16;
  localparam int unsigned GT   = 4;
  localparam logic [7:0]  SEED = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ins = '0;
  logic [3:0] count;
  logic       mo1, mo2, mo3, mo4;
  logic [3:0] mo_v;

  assign mo_v = {mo4, mo3, mo2, mo1};

  always #5 clk = ~clk;

  whack_a_mole_core #(
    .MOLE_TIME(MT),
    .GAP_TIME (GT),
    .LFSR_SEED(SEED)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in1  (ins[0]),
    .in2  (ins[1]),
    .in3  (ins[2]),
    .in4  (ins[3]),
    .count(count),
    .mo1  (mo1),
    .mo2  (mo2),
    .mo3  (mo3),
    .mo4  (mo4)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];

  // Reference game: countdown of cycles left in the current phase, mole index or -1.
  int         m_score;
  int         m_mole;
  int         m_left;
  logic [7:0] m_lfsr;
  logic [3:0] m_hist[$];

  always @(posedge clk) begin
    logic [3:0] press;
    logic [3:0] mo_e;
    if (!rst_n) begin
      m_score = 0;
      m_mole  = -1;
      m_left  = GT;
      m_lfsr  = SEED;
      m_hist  = {4'h0, 4'h0, 4'h0};
    end else begin
      // a button press reaches the game two edges after it is first sampled
      press = m_hist[1] & ~m_hist[0];
      void'(m_hist.pop_front());
      m_hist.push_back(ins);
      if (m_mole < 0) begin
        m_left--;
        if (m_left == 0) begin
          m_mole = int'(m_lfsr % 8'd4);
          m_left = MT;
        end
      end else if (press[m_mole]) begin
        m_score = (m_score < 15) ? m_score + 1 : 15;
        m_mole  = -1;
        m_left  = GT;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_mole = -1;
          m_left = GT;
        end
      end
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end
    mo_e = (m_mole < 0) ? 4'h0 : 4'(1 << m_mole);
    exp_q.push_back({4'(m_score), mo_e});
  end

  always @(negedge clk) begin
    logic [7:0] e;
    logic [7:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {count, mo_v};
      tests++;
      if (a !== e) begin
        fails++;
        if (fails <= 20)
          $display("FAIL scoreboard t=%0t got count=%0d mo=%b expected count=%0d mo=%b",
                   $time, a[7:4], a[3:0], e[7:4], e[3:0]);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // All stimulus tasks run at negedges: set inputs now, then wait one cycle.
  task automatic step(input logic [3:0] v);
    ins = v;
    @(negedge clk);
  endtask

  task automatic wait_up(output int idx);
    idx = -1;
    for (int i = 0; i < 400; i++) begin
      if (mo_v != 4'h0) begin
        case (mo_v)
          4'b0001: idx = 0;
          4'b0010: idx = 1;
          4'b0100: idx = 2;
          default: idx = 3;
        endcase
        return;
      end
      @(negedge clk);
    end
    tests++;
    fails++;
    $display("FAIL wait_up timeout got mo=%b expected a raised mole", mo_v);
  endtask

  task automatic wait_down();
    for (int i = 0; i < 400; i++) begin
      if (mo_v == 4'h0) return;
      @(negedge clk);
    end
    tests++;
    fails++;
    $display("FAIL wait_down timeout got mo=%b expected 0000", mo_v);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] bounce [9];
    bounce = '{4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd1, 4'd1, 4'd0, 4'd1};

    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) begin
      ins = 4'($urandom);
      @(negedge clk);
    end
    chk("reset_count", int'(count), 0);
    chk("reset_mo", int'(mo_v), 0);
    ins   = '0;
    rst_n = 1'b1;

    // correct hit, held for 7 cycles
    wait_up(n);
    if (n >= 0) begin
      repeat (7) step(4'(1 << n));
      step('0);
      chk("first_hit_count", int'(count), 1);
    end

    // wrong button during UP, then full timeout
    wait_down();
    wait_up(n);
    if (n >= 0) begin
      repeat (2) step(4'(1 << ((n + 1) % 4)));
      step('0);
      wait_down();
    end

    // press during GAP
    wait_up(n);
    wait_down();
    step(4'($urandom_range(1, 15)));
    step('0);

    // untouched mole times out
    wait_up(n);
    wait_down();

    // bouncing matching button
    wait_up(n);
    if (n >= 0) begin
      for (int i = 0; i < 9; i++) step(bounce[i] != 4'd0 ? 4'(1 << n) : 4'h0);
      repeat (4) step('0);
    end

    // random play
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
    step('0);

    // fresh game, then drive the score into saturation
    rst_n = 1'b0;
    repeat (2) step('0);
    rst_n = 1'b1;
    for (int k = 0; k < 17; k++) begin
      wait_up(n);
      if (n >= 0) begin
        repeat (2) step(4'(1 << n));
        step('0);
        wait_down();
      end
    end
    chk("saturate_count", int'(count), 15);

    // asynchronous reset while a mole is up
    wait_up(n);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_count", int'(count), 0);
    chk("async_reset_mo", int'(mo_v), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0);
    repeat (3) step('0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/whack_a_mole_core.md
Name: whack_a_mole_core

Overview:
Game core for a four-hole whack-a-mole. A pseudo-random LFSR raises one mole at a time on mo1..mo4. Four player buttons in1..in4 are synchronised and edge-detected. A press on the button matching the raised mole scores a hit in the 4-bit count. The block sits between debounced or raw push-buttons and the LED/score display logic.

Parameters:
MOLE_TIME, 16: maximum cycles a mole stays raised (valid range 1..255).
GAP_TIME, 4: cycles with all moles down between appearances (valid range 1..255).
LFSR_SEED, 8'hA5: reset value of the 8-bit LFSR; must be non-zero.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in1  input  1  button for hole 1, active-high, asynchronous to clk.
in2  input  1  button for hole 2.
in3  input  1  button for hole 3.
in4  input  1  button for hole 4.
count  output  4  hit score, registered.
mo1  output  1  mole 1 raised, registered.
mo2  output  1  mole 2 raised, registered.
mo3  output  1  mole 3 raised, registered.
mo4  output  1  mole 4 raised, registered.

Behaviour:
- Reset (rst_n=0, asynchronous) sets:
  - count=0 and mo1..mo4=0.
  - FSM=GAP with the timer cleared.
  - LFSR=LFSR_SEED.
  - Synchroniser and edge-detect flops cleared to 0.
- Input path, per button:
  - Two-flop synchroniser (s1, s2) feeds a history flop (s2_d).
  - press_k = s2 & ~s2_d. This is one pulse per rising edge, however long the button is held.
  - Latency: an input high before edge E appears in s2 after edge E+1. The resulting count/mole update lands on edge E+2.
  - Glitches shorter than one clock period that miss every sampling edge are ignored.
- LFSR:
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, shifting every cycle including GAP.
  - Never reaches zero.
- FSM states:
  - GAP: all mo=0. Timer counts up from 0. When timer==GAP_TIME-1, go to UP with timer cleared. On that transition, latch mole index idx=lfsr[1:0] (00→mo1, 01→mo2, 10→mo3, 11→mo4) and assert that single mo output on the same edge.
  - UP: exactly one mo bit=1 (one-hot), all others 0.
    - Hit: press for the matching button. count increments, the mole drops (mo=0), state goes to GAP with timer cleared. All of this happens on the same edge.
    - Timeout: timer==MOLE_TIME-1 with no hit. The mole drops, state goes to GAP, count is unchanged.
    - A hit on the final cycle of UP takes priority over timeout.
- Presses in GAP, and presses of non-matching buttons in UP, are ignored: no score change, no penalty.
- Simultaneous presses: if the matching button is among them, it counts as one hit (+1 only).
- Bouncing input: at most one hit per mole appearance. The mole drops on the first hit, so later edges fall into GAP and are ignored.
- Score saturates at 15. A hit at 15 still drops the mole but leaves count=15. There is no wrap to 0.
- Reset mid-game returns to the reset state immediately. Play restarts with GAP after rst_n deasserts.
- Outputs are registered directly from flops, so there are no combinational paths from the in* inputs to any output.

Test Plan:
- Reset: rst_n=0 for 3 cycles with random in* -> count=0, mo1..4=0. Then release -> all mo=0 for exactly GAP_TIME cycles, after which exactly one mo goes high.
- Correct hit: wait for moN=1, then pulse the matching inN high for 7 cycles -> count goes 0→1 two edges after the first sampling edge. moN falls on the same edge. count stays 1 while the button is held.
- Wrong button and gap press:
  - Pulse a non-matching button during UP -> count unchanged, mole stays up until timeout.
  - Press during GAP -> count unchanged.
- Timeout: raise a mole, no press -> the mole drops after exactly MOLE_TIME cycles, count unchanged, next mole appears after GAP_TIME cycles.
- Bounce: matching button toggles high 3 cycles, low 2, high 2, low 1, high 1 -> count +1 only.
- Saturation and reset:
  - Score 16 hits -> count holds at 15.
  - Assert rst_n=0 asynchronously mid-UP -> count=0 and all mo=0 before the next clk edge.
